// File: rtl/t9990_blit_walk.sv
// t9990_blit_walk: rectangle address walker for the T9990 blitter.
// Steps one pixel per accepted transfer and presents the VRAM word address
// and the pixel index within that word, with a valid/ready handshake.
// Optional build macro T9990_BLIT_WALK_CLIP_EN: elements beyond the image
// width are skipped internally instead of being emitted.
// Assumes X_W >= 10 and Y_W >= ADDR_W-8, as required by the P1 layout.
module t9990_blit_walk #(
   parameter int X_W    = 11,
   parameter int Y_W    = 12,
   parameter int ADDR_W = 19
) (
   input  logic              CLK,
   input  logic              RESET_n,
   input  logic              START,
   input  logic              ABORT,
   input  logic [X_W-1:0]    SX,
   input  logic [Y_W-1:0]    SY,
   input  logic [X_W-1:0]    NX,
   input  logic [Y_W-1:0]    NY,
   input  logic              DIX,
   input  logic              DIY,
   input  logic [1:0]        CLRM,
   input  logic [1:0]        XIMM,
   input  logic              P1,
   output logic              VALID,
   input  logic              READY,
   output logic [ADDR_W-1:0] ADDR,
   output logic [3:0]        PIX,
   output logic              LAST,
   output logic              BUSY,
   output logic              DONE
);
   // wide enough for any intermediate of the linear address computation
   localparam int FW = ADDR_W + X_W + Y_W + 2;

   typedef enum logic {IDLE, RUN} state_t;
   state_t state;

   logic [X_W-1:0]    sx_r, nxm1_r, cx, colc;
   logic [Y_W-1:0]    cy, rowc;
   logic              dix_r, diy_r, p1_r, clip_r;
   logic [1:0]        clrm_r, ximm_r;

   logic [X_W-1:0]    n_cx, n_col;
   logic [Y_W-1:0]    n_cy, n_row;
   logic [1:0]        m_clrm, m_ximm;
   logic              m_p1;
   logic [2:0]        s;
   logic [3:0]        w;
   logic [FW-1:0]     cxw, word;
   logic [ADDR_W-1:0] m_addr;
   logic [3:0]        m_pix;
   logic              m_clip, m_last;

   // coordinates/counters of the element to present next (first one when idle)
   always_comb begin
      n_cx  = cx;
      n_cy  = cy;
      n_col = colc;
      n_row = rowc;
      if (state == IDLE) begin
         n_cx  = SX;
         n_cy  = SY;
         n_col = NX - 1'b1;
         n_row = NY - 1'b1;
      end else if (colc == '0) begin
         n_cx  = sx_r;
         n_cy  = diy_r ? cy - 1'b1 : cy + 1'b1;
         n_col = nxm1_r;
         n_row = rowc - 1'b1;
      end else begin
         n_cx  = dix_r ? cx - 1'b1 : cx + 1'b1;
         n_col = colc - 1'b1;
      end
   end

   // map the next coordinates to word address / pixel index in the active mode
   always_comb begin
      m_clrm = (state == IDLE) ? CLRM : clrm_r;
      m_ximm = (state == IDLE) ? XIMM : ximm_r;
      m_p1   = (state == IDLE) ? P1   : p1_r;
      s      = 3'd4 - {1'b0, m_clrm};   // log2(pixels per word)
      w      = 4'd8 + {2'b00, m_ximm};  // log2(image width)
      cxw    = FW'(n_cx);
      m_last = (n_col == '0) && (n_row == '0);
      m_clip = 1'b0;
      word   = '0;
      if (m_p1) begin
         m_addr = {n_cx[9] ^ n_cy[Y_W-1], n_cy[ADDR_W-9:0], n_cx[7:3], 2'b00};
         m_pix  = {1'b0, n_cx[2:0]};
`ifdef T9990_BLIT_WALK_CLIP_EN
         m_clip = (cxw >> 10) != '0;
`endif
      end else begin
         // x bits at and above w are dropped, so wide x aliases onto the row
         word   = (FW'(n_cy) << (w - 4'(s))) | ((cxw & ((FW'(1) << w) - 1'b1)) >> s);
         m_addr = ADDR_W'(word << 2);
         m_pix  = 4'(cxw & ((FW'(1) << s) - 1'b1));
`ifdef T9990_BLIT_WALK_CLIP_EN
         m_clip = (cxw >> w) != '0;
`endif
      end
   end

   // walk control: latch on start, step on handshake (or clip), finish/abort
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state  <= IDLE;
         VALID  <= 1'b0;
         LAST   <= 1'b0;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
         ADDR   <= '0;
         PIX    <= '0;
         sx_r   <= '0;
         nxm1_r <= '0;
         cx     <= '0;
         cy     <= '0;
         colc   <= '0;
         rowc   <= '0;
         dix_r  <= 1'b0;
         diy_r  <= 1'b0;
         p1_r   <= 1'b0;
         clrm_r <= '0;
         ximm_r <= '0;
         clip_r <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (START && NX != '0 && NY != '0) begin
                  state  <= RUN;
                  sx_r   <= SX;
                  nxm1_r <= NX - 1'b1;
                  dix_r  <= DIX;
                  diy_r  <= DIY;
                  p1_r   <= P1;
                  clrm_r <= CLRM;
                  ximm_r <= XIMM;
                  cx     <= n_cx;
                  cy     <= n_cy;
                  colc   <= n_col;
                  rowc   <= n_row;
                  ADDR   <= m_addr;
                  PIX    <= m_pix;
                  VALID  <= !m_clip;
                  LAST   <= m_last && !m_clip;
                  clip_r <= m_clip;
                  BUSY   <= 1'b1;
               end
            end
            RUN: begin
               if (ABORT) begin
                  state  <= IDLE;
                  VALID  <= 1'b0;
                  LAST   <= 1'b0;
                  BUSY   <= 1'b0;
                  clip_r <= 1'b0;
                  DONE   <= 1'b1;
               end else if ((VALID && READY) || clip_r) begin
                  if (colc == '0 && rowc == '0) begin
                     state  <= IDLE;
                     VALID  <= 1'b0;
                     LAST   <= 1'b0;
                     BUSY   <= 1'b0;
                     clip_r <= 1'b0;
                     DONE   <= 1'b1;
                  end else begin
                     cx     <= n_cx;
                     cy     <= n_cy;
                     colc   <= n_col;
                     rowc   <= n_row;
                     ADDR   <= m_addr;
                     PIX    <= m_pix;
                     VALID  <= !m_clip;
                     LAST   <= m_last && !m_clip;
                     clip_r <= m_clip;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_t9990_blit_walk.sv
// Directed bench for t9990_blit_walk: table of single-pixel mapping vectors
// plus hand-written multi-cycle walks (stall, wrap/clip, abort, reset, ignores).
module tb_t9990_blit_walk;
   logic        CLK = 1'b0;
   logic        RESET_n, START, ABORT, DIX, DIY, P1, READY;
   logic [10:0] SX, NX;
   logic [11:0] SY, NY;
   logic [1:0]  CLRM, XIMM;
   logic        VALID, LAST, BUSY, DONE;
   logic [18:0] ADDR;
   logic [3:0]  PIX;

   t9990_blit_walk #(.X_W(11), .Y_W(12), .ADDR_W(19)) dut (
      .CLK(CLK), .RESET_n(RESET_n), .START(START), .ABORT(ABORT),
      .SX(SX), .SY(SY), .NX(NX), .NY(NY), .DIX(DIX), .DIY(DIY),
      .CLRM(CLRM), .XIMM(XIMM), .P1(P1), .VALID(VALID), .READY(READY),
      .ADDR(ADDR), .PIX(PIX), .LAST(LAST), .BUSY(BUSY), .DONE(DONE));

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  clrm, ximm;
      logic        p1;
      logic [10:0] sx;
      logic [11:0] sy;
      logic [18:0] addr;
      logic [3:0]  pix;
   } vec_t;
   vec_t tbl[8];

   // per-walk capture
   logic [18:0] qa[$];
   logic [3:0]  qp[$];
   logic        ql[$];
   logic [18:0] sa[$];
   logic [3:0]  spx[$];
   logic        hv[32], hb[32], hd[32];
   int          busy_n, done_n;

   task automatic set_walk(input logic [1:0] c, input logic [1:0] x, input logic p,
                           input logic [10:0] sx_, input logic [11:0] sy_,
                           input logic [10:0] nx_, input logic [11:0] ny_,
                           input logic dx, input logic dy);
      CLRM = c; XIMM = x; P1 = p; SX = sx_; SY = sy_; NX = nx_; NY = ny_; DIX = dx; DIY = dy;
   endtask

   // called just after a rising edge; START is sampled at the next edge
   task automatic start_walk();
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   // run ncyc cycles; READY low for [rs, rs+rl), START pulse (with junk
   // operands) at cycle sp, ABORT at cycle ab; cycle 0 follows the START edge
   task automatic collect(input int ncyc, input int rs, input int rl, input int sp, input int ab);
      qa.delete(); qp.delete(); ql.delete(); sa.delete(); spx.delete();
      busy_n = 0; done_n = 0;
      for (int k = 0; k < ncyc; k++) begin
         READY = !(k >= rs && k < rs + rl);
         ABORT = (k == ab);
         if (k == sp) begin
            START = 1'b1; SX = 11'h7F0; SY = 12'h0AA; NX = 11'd5;
            CLRM = 2'd0; XIMM = 2'd3; P1 = 1'b1; DIX = 1'b1;
         end else begin
            START = 1'b0;
         end
         @(negedge CLK);
         hv[k] = VALID; hb[k] = BUSY; hd[k] = DONE;
         if (BUSY) busy_n++;
         if (DONE) done_n++;
         if (VALID && READY) begin qa.push_back(ADDR); qp.push_back(PIX); ql.push_back(LAST); end
         if (VALID && !READY) begin sa.push_back(ADDR); spx.push_back(PIX); end
         @(posedge CLK); #1;
      end
      READY = 1'b1; ABORT = 1'b0; START = 1'b0;
   endtask

   // expected element list for the 4bpp/256 2x2 walk at (8,2)
   logic [18:0] ea[4];
   logic [3:0]  ep[4];
   logic        el[4];

   task automatic chk_walk_a(input string nm);
      chk({nm, " count"}, qa.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < qa.size()) begin
            chk($sformatf("%s addr%0d", nm, i), qa[i], ea[i]);
            chk($sformatf("%s pix%0d", nm, i), qp[i], ep[i]);
            chk($sformatf("%s last%0d", nm, i), ql[i], el[i]);
         end
      end
   endtask

   initial begin
      tbl[0] = '{2'd1, 2'd0, 1'b0, 11'h008, 12'h002, 19'h00104, 4'd0};
      tbl[1] = '{2'd0, 2'd0, 1'b0, 11'h035, 12'h001, 19'h0004C, 4'd5};
      tbl[2] = '{2'd2, 2'd1, 1'b0, 11'h1FF, 12'h003, 19'h007FC, 4'd3};
      tbl[3] = '{2'd3, 2'd3, 1'b0, 11'h7FF, 12'h005, 19'h05FFC, 4'd1};
      tbl[4] = '{2'd3, 2'd2, 1'b0, 11'h3FE, 12'hFFF, 19'h7FFFC, 4'd0};
      tbl[5] = '{2'd0, 2'd0, 1'b1, 11'h208, 12'h000, 19'h40004, 4'd0};
      tbl[6] = '{2'd2, 2'd1, 1'b1, 11'h0FF, 12'h801, 19'h400FC, 4'd7};
      tbl[7] = '{2'd1, 2'd3, 1'b1, 11'h3C5, 12'h003, 19'h401E0, 4'd5};
      ea = '{19'h104, 19'h104, 19'h184, 19'h184};
      ep = '{4'd0, 4'd1, 4'd0, 4'd1};
      el = '{1'b0, 1'b0, 1'b0, 1'b1};

      RESET_n = 1'b0; START = 1'b0; ABORT = 1'b0; READY = 1'b1;
      set_walk(2'd0, 2'd0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
      repeat (2) @(posedge CLK);
      #1;
      chk("reset outs", {VALID, LAST, BUSY, DONE, PIX, ADDR}, 32'h0);
      #3 RESET_n = 1'b1;
      @(posedge CLK); #1;

      // single-pixel mapping vectors
      for (int i = 0; i < 8; i++) begin
         set_walk(tbl[i].clrm, tbl[i].ximm, tbl[i].p1, tbl[i].sx, tbl[i].sy, 11'd1, 12'd1, 1'b0, 1'b0);
         start_walk();
         collect(4, -1, 0, -1, -1);
         chk($sformatf("vec%0d count", i), qa.size(), 1);
         if (qa.size() > 0) begin
            chk($sformatf("vec%0d addr", i), qa[0], tbl[i].addr);
            chk($sformatf("vec%0d pix", i), qp[0], tbl[i].pix);
            chk($sformatf("vec%0d last", i), ql[0], 1);
         end
         chk($sformatf("vec%0d done", i), done_n, 1);
      end

      // 2x2 walk at full rate
      set_walk(2'd1, 2'd0, 1'b0, 11'd8, 12'd2, 11'd2, 12'd2, 1'b0, 1'b0);
      start_walk();
      collect(8, -1, 0, -1, -1);
      chk_walk_a("walkA");
      chk("walkA done cycle", hd[4], 1);
      chk("walkA done count", done_n, 1);
      chk("walkA busy span", busy_n + 1, 5);
      chk("walkA busy after", hb[4], 0);

      // same walk with READY low 3 cycles on the second element
      set_walk(2'd1, 2'd0, 1'b0, 11'd8, 12'd2, 11'd2, 12'd2, 1'b0, 1'b0);
      start_walk();
      collect(12, 1, 3, -1, -1);
      chk_walk_a("stall");
      chk("stall samples", sa.size(), 3);
      for (int i = 0; i < sa.size(); i++) begin
         chk($sformatf("stall hold addr%0d", i), sa[i], 19'h104);
         chk($sformatf("stall hold pix%0d", i), spx[i], 4'd1);
      end
      chk("stall busy span", busy_n + 1, 8);
      chk("stall done cycle", hd[7], 1);

      // START while busy (with changed operands/mode) is ignored
      set_walk(2'd1, 2'd0, 1'b0, 11'd8, 12'd2, 11'd2, 12'd2, 1'b0, 1'b0);
      start_walk();
      collect(8, -1, 0, 1, -1);
      chk_walk_a("startbusy");
      chk("startbusy done", done_n, 1);

      // X decrement wrapping past zero, 16bpp/512
      set_walk(2'd3, 2'd1, 1'b0, 11'd0, 12'd0, 11'd2, 12'd1, 1'b1, 1'b0);
      start_walk();
      collect(6, -1, 0, -1, -1);
`ifdef T9990_BLIT_WALK_CLIP_EN
      chk("wrap count", qa.size(), 1);
      if (qa.size() > 0) begin
         chk("wrap addr0", qa[0], 19'h000);
         chk("wrap last0", ql[0], 0);
      end
`else
      chk("wrap count", qa.size(), 2);
      if (qa.size() > 1) begin
         chk("wrap addr0", qa[0], 19'h000);
         chk("wrap last0", ql[0], 0);
         chk("wrap addr1", qa[1], 19'h3FC);
         chk("wrap pix1", qp[1], 4'd1);
         chk("wrap last1", ql[1], 1);
      end
`endif
      chk("wrap done cycle", hd[2], 1);
      chk("wrap done count", done_n, 1);

      // abort together with READY on the third element of a 4x4 walk
      set_walk(2'd1, 2'd0, 1'b0, 11'd0, 12'd0, 11'd4, 12'd4, 1'b0, 1'b0);
      start_walk();
      collect(8, -1, 0, -1, 2);
      chk("abort valid before", hv[2], 1);
      chk("abort valid after", hv[3], 0);
      chk("abort busy after", hb[3], 0);
      chk("abort done pulse", hd[3], 1);
      chk("abort done count", done_n, 1);

      // reset in the middle of a walk
      set_walk(2'd1, 2'd0, 1'b0, 11'd0, 12'd0, 11'd4, 12'd4, 1'b0, 1'b0);
      start_walk();
      @(posedge CLK); #1;
      chk("midwalk busy", BUSY, 1);
      #2 RESET_n = 1'b0;
      #1 chk("midreset outs", {VALID, LAST, BUSY, DONE, PIX, ADDR}, 32'h0);
      #3 RESET_n = 1'b1;
      @(posedge CLK); #1;
      collect(5, -1, 0, -1, -1);
      chk("midreset no done", done_n, 0);
      chk("midreset idle", busy_n, 0);

      // START with NX=0 is ignored
      set_walk(2'd1, 2'd0, 1'b0, 11'd8, 12'd2, 11'd0, 12'd2, 1'b0, 1'b0);
      start_walk();
      collect(4, -1, 0, -1, -1);
      chk("nx0 busy", busy_n, 0);
      chk("nx0 done", done_n, 0);
      chk("nx0 elems", qa.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
